order_msg_parser: RTL

//  Consumes the payload byte stream from the Ethernet RX stage and decodes fixed 12-byte

---
 rtl/order_msg_parser_if.sv | 32 +++
 rtl/order_msg_parser.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/order_msg_parser_if.sv
// Byte-stream input and decoded-message output of the order message parser.
// The parser sits on the slave side; the RX stage and consumer sit on master.
interface order_msg_parser_if #(
   parameter int unsigned CNT_W = 16
) ();
   logic [7:0]       in_byte;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic             msg_valid;
   logic             msg_ready;
   logic [7:0]       msg_type;
   logic [15:0]      msg_sym;
   logic             msg_side;
   logic [31:0]      msg_price;
   logic [31:0]      msg_qty;
   logic             err_pulse;
   logic [CNT_W-1:0] msg_count;
   logic [CNT_W-1:0] err_count;

   modport master (
      output in_byte, in_valid, in_last, msg_ready,
      input  in_ready, msg_valid, msg_type, msg_sym, msg_side, msg_price, msg_qty,
      input  err_pulse, msg_count, err_count
   );

   modport slave (
      input  in_byte, in_valid, in_last, msg_ready,
      output in_ready, msg_valid, msg_type, msg_sym, msg_side, msg_price, msg_qty,
      output err_pulse, msg_count, err_count
   );
endinterface

// File: rtl/order_msg_parser.sv
// Decodes fixed 12-byte big-endian order messages from a payload byte stream; malformed
// messages are dropped and counted, good ones are offered on a valid/ready handshake.
module order_msg_parser #(
   parameter logic [7:0]  TYPE_NEW = 8'h4F,
   parameter logic [7:0]  TYPE_CXL = 8'h58,
   parameter int unsigned CNT_W    = 16
) (
   input logic              clk,
   input logic              rst_n,
   order_msg_parser_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StFields, StPad, StDrop} state_e;

   localparam logic [7:0] SideBuy  = 8'h42;
   localparam logic [7:0] SideSell = 8'h53;

   state_e           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [87:0]      stage_q, stage_d;
   logic             msg_valid_q, msg_valid_d;
   logic [7:0]       type_q, type_d;
   logic [15:0]      sym_q, sym_d;
   logic             side_q, side_d;
   logic [31:0]      price_q, price_d;
   logic [31:0]      qty_q, qty_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic        in_ready;
   logic        accept;
   logic        side_ok;
   logic [95:0] full;

   assign in_ready = !msg_valid_q || bus.msg_ready;
   assign accept   = bus.in_valid && in_ready;
   assign side_ok  = (bus.in_byte == SideBuy) || (bus.in_byte == SideSell);
   // Bytes 0..10 sit in stage_q; the byte being accepted completes the message.
   assign full     = {stage_q, bus.in_byte};

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      stage_d     = stage_q;
      msg_valid_d = msg_valid_q && !bus.msg_ready;
      type_d      = type_q;
      sym_d       = sym_q;
      side_d      = side_q;
      price_d     = price_q;
      qty_d       = qty_q;
      err_d       = 1'b0;
      msg_cnt_d   = msg_cnt_q;
      err_cnt_d   = err_cnt_q;

      if (accept) begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_byte == TYPE_NEW || bus.in_byte == TYPE_CXL) begin
                  stage_d = {stage_q[79:0], bus.in_byte};
                  idx_d   = 4'd1;
                  state_d = StFields;
                  // A payload ending right after the type byte is a truncated message.
                  err_d   = bus.in_last;
               end else if (bus.in_byte == 8'h00) begin
                  state_d = StPad;
               end else begin
                  err_d   = 1'b1;
                  state_d = StDrop;
               end
            end
            StFields: begin
               stage_d = {stage_q[79:0], bus.in_byte};
               idx_d   = idx_q + 4'd1;
               if (idx_q == 4'd3 && !side_ok) begin
                  err_d   = 1'b1;
                  state_d = StDrop;
               end else if (idx_q == 4'd11) begin
                  msg_valid_d = 1'b1;
                  type_d      = full[95:88];
                  sym_d       = full[87:72];
                  side_d      = (full[71:64] == SideSell);
                  price_d     = full[63:32];
                  qty_d       = full[31:0];
                  idx_d       = 4'd0;
                  state_d     = StIdle;
               end else begin
                  err_d = bus.in_last;
               end
            end
            default: ;
         endcase
         if (bus.in_last) begin
            state_d = StIdle;
            idx_d   = 4'd0;
         end
      end

      if (msg_valid_q && bus.msg_ready && msg_cnt_q != '1) begin
         msg_cnt_d = msg_cnt_q + 1'b1;
      end
      if (err_d && err_cnt_q != '1) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         idx_q       <= 4'd0;
         stage_q     <= '0;
         msg_valid_q <= 1'b0;
         type_q      <= '0;
         sym_q       <= '0;
         side_q      <= 1'b0;
         price_q     <= '0;
         qty_q       <= '0;
         err_q       <= 1'b0;
         msg_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         stage_q     <= stage_d;
         msg_valid_q <= msg_valid_d;
         type_q      <= type_d;
         sym_q       <= sym_d;
         side_q      <= side_d;
         price_q     <= price_d;
         qty_q       <= qty_d;
         err_q       <= err_d;
         msg_cnt_q   <= msg_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.msg_valid = msg_valid_q;
   assign bus.msg_type  = type_q;
   assign bus.msg_sym   = sym_q;
   assign bus.msg_side  = side_q;
   assign bus.msg_price = price_q;
   assign bus.msg_qty   = qty_q;
   assign bus.err_pulse = err_q;
   assign bus.msg_count = msg_cnt_q;
   assign bus.err_count = err_cnt_q;

endmodule
